// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch and data ports.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP; data wins conflicts unless fetch has starved.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned IF_STARVE_MAX = 4,
  parameter logic [31:0] IF_BASE       = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_ready_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        stall_o
);

  localparam int unsigned SW = $clog2(IF_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(IF_STARVE_MAX);
  localparam logic [2:0]    LAT        = 3'(MEM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          port_q, port_d;   // 1 = data port owns the access
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    wait_q, wait_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   if_data_q, if_data_d;
  logic [31:0]   d_data_q, d_data_d;
  logic          grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wait_q    <= 3'd0;
      starve_q  <= '0;
      if_data_q <= 32'h0;
      d_data_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      if_data_q <= if_data_d;
      d_data_q  <= d_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    if_data_d = if_data_q;
    d_data_d  = d_data_q;
    grant_if  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_ce_i || d_ce_i) begin
          grant_if = if_ce_i && (!d_ce_i || (starve_q == STARVE_MAX));
          state_d  = S_ISSUE;
          if (grant_if) begin
            port_d   = 1'b0;
            we_d     = 1'b0;
            sel_d    = 4'b1111;
            addr_d   = if_addr_i - IF_BASE;
            starve_d = '0;
          end else begin
            port_d  = 1'b1;
            we_d    = d_we_i;
            sel_d   = d_sel_i;
            addr_d  = d_addr_i;
            wdata_d = d_data_i;
            // Count data grants that made a waiting fetch lose; saturate at the limit.
            if (!if_ce_i)                    starve_d = '0;
            else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = 3'd1;
      end
      S_WAIT: begin
        if (wait_q == LAT) begin
          state_d = S_RESP;
          if (!port_q)    if_data_d = mem_data_i;
          else if (!we_q) d_data_d  = mem_data_i;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_ce_o   = (state_q == S_ISSUE);
  assign mem_we_o   = (state_q == S_ISSUE) && we_q && port_q;
  assign mem_sel_o  = sel_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign if_ready_o = (state_q == S_RESP) && !port_q;
  assign d_ready_o  = (state_q == S_RESP) && port_q;
  assign if_data_o  = if_data_q;
  assign d_data_o   = d_data_q;
  assign stall_o    = (if_ce_i && !if_ready_o) || (d_ce_i && !d_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a uses default parameters,
// instance b uses MEM_LATENCY=3 and IF_STARVE_MAX=2; each has its own memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce;
  logic [31:0] if_addr;
  logic        d_ce, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr, d_wdata;

  logic [31:0] a_if_data, a_d_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_ready, a_d_ready, a_mem_ce, a_mem_we, a_stall;
  logic [3:0]  a_mem_sel;
  logic [31:0] b_if_data, b_d_data, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_ready, b_d_ready, b_mem_ce, b_mem_we, b_stall;
  logic [3:0]  b_mem_sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter u_a (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(a_if_data), .if_ready_o(a_if_ready),
    .d_ce_i(d_ce), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr), .d_data_i(d_wdata),
    .d_data_o(a_d_data), .d_ready_o(a_d_ready),
    .mem_ce_o(a_mem_ce), .mem_we_o(a_mem_we), .mem_sel_o(a_mem_sel), .mem_addr_o(a_mem_addr),
    .mem_data_o(a_mem_wdata), .mem_data_i(a_mem_rdata), .stall_o(a_stall)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .IF_STARVE_MAX(2)) u_b (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(b_if_data), .if_ready_o(b_if_ready),
    .d_ce_i(d_ce), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr), .d_data_i(d_wdata),
    .d_data_o(b_d_data), .d_ready_o(b_d_ready),
    .mem_ce_o(b_mem_ce), .mem_we_o(b_mem_we), .mem_sel_o(b_mem_sel), .mem_addr_o(b_mem_addr),
    .mem_data_o(b_mem_wdata), .mem_data_i(b_mem_rdata), .stall_o(b_stall)
  );

  // Memory contents: one fixed instruction word, everything else is a fold of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'h2402000A : (addr ^ 32'hA5A5A5A5);
  endfunction

  // Read data is valid only in the cycle exactly MEM_LATENCY after mem_ce_o.
  logic [7:0]  a_hist = '0;
  logic [31:0] a_ahist [8];
  logic [7:0]  b_hist = '0;
  logic [31:0] b_ahist [8];

  always @(posedge clk) begin
    #1;
    for (int i = 7; i > 0; i--) begin
      a_hist[i] = a_hist[i-1]; a_ahist[i] = a_ahist[i-1];
      b_hist[i] = b_hist[i-1]; b_ahist[i] = b_ahist[i-1];
    end
    a_hist[0] = a_mem_ce; a_ahist[0] = a_mem_addr;
    b_hist[0] = b_mem_ce; b_ahist[0] = b_mem_addr;
    a_mem_rdata = a_hist[1] ? mem_word(a_ahist[1]) : 32'hBAD0BAD0;
    b_mem_rdata = b_hist[3] ? mem_word(b_ahist[3]) : 32'hBAD0BAD0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_sel [6];
  int n;
  logic seen;

  initial begin
    exp_sel = '{4'h5, 4'h5, 4'hF, 4'h5, 4'h5, 4'hF};
    a_mem_rdata = 32'h0;
    b_mem_rdata = 32'h0;

    // Test 1: reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_ce   = 1'($urandom_range(0, 1));
      d_ce    = 1'($urandom_range(0, 1));
      d_we    = 1'($urandom_range(0, 1));
      d_sel   = 4'($urandom_range(0, 15));
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      step();
      chk("rst_stall", {31'h0, a_stall}, {31'h0, if_ce | d_ce});
    end
    chk("rst_ctl", {24'h0, a_mem_ce, a_mem_we, a_mem_sel, a_if_ready, a_d_ready}, 32'h0);
    chk("rst_addr", a_mem_addr, 32'h0);
    chk("rst_wdata", a_mem_wdata, 32'h0);
    chk("rst_if_data", a_if_data, 32'h0);
    chk("rst_d_data", a_d_data, 32'h0);
    chk("rst_b_ctl", {24'h0, b_mem_ce, b_mem_we, b_mem_sel, b_if_ready, b_d_ready}, 32'h0);
    rst = 1'b0; if_ce = 1'b0; d_ce = 1'b0; d_we = 1'b0;
    #1;
    chk("idle_stall", {31'h0, a_stall}, 32'h0);

    // Test 2: single fetch, latency 1
    if_ce = 1'b1; if_addr = 32'h00400010;
    step();
    chk("f_ce_c1", {31'h0, a_mem_ce}, 32'h1);
    chk("f_addr_c1", a_mem_addr, 32'h10);
    chk("f_sel_we_c1", {27'h0, a_mem_sel, a_mem_we}, {27'h0, 4'hF, 1'b0});
    chk("f_stall_c1", {31'h0, a_stall}, 32'h1);
    step();
    chk("f_ce_c2", {30'h0, a_mem_ce, a_if_ready}, 32'h0);
    step();
    chk("f_ready_c3", {31'h0, a_if_ready}, 32'h1);
    chk("f_data_c3", a_if_data, 32'h2402000A);
    chk("f_stall_c3", {31'h0, a_stall}, 32'h0);
    step();
    if_ce = 1'b0;
    chk("f_ready_c4", {31'h0, a_if_ready}, 32'h0);
    chk("f_data_hold", a_if_data, 32'h2402000A);
    step();

    // Test 3: simultaneous fetch and load, data first
    if_ce = 1'b1; if_addr = 32'h00400020;
    d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h10010000; d_wdata = 32'h12345678;
    #1;
    chk("c_stall_c0", {31'h0, a_stall}, 32'h1);
    step();
    chk("c_ce_c1", {30'h0, a_mem_ce, a_mem_we}, 32'h2);
    chk("c_addr_c1", a_mem_addr, 32'h10010000);
    step();
    step();
    chk("c_dready_c3", {30'h0, a_d_ready, a_if_ready}, 32'h2);
    chk("c_ddata_c3", a_d_data, 32'hB5A4A5A5);
    chk("c_stall_c3", {31'h0, a_stall}, 32'h1);
    chk("c_ifdata_keep", a_if_data, 32'h2402000A);
    step();
    d_ce = 1'b0;
    #1;
    chk("c_stall_c4", {31'h0, a_stall}, 32'h1);
    step();
    chk("c_ce_c5", {31'h0, a_mem_ce}, 32'h1);
    chk("c_addr_c5", a_mem_addr, 32'h20);
    chk("c_sel_c5", {28'h0, a_mem_sel}, 32'hF);
    step();
    step();
    chk("c_ifready_c7", {30'h0, a_if_ready, a_d_ready}, 32'h2);
    chk("c_ifdata_c7", a_if_data, 32'hA5A5A585);
    chk("c_ddata_keep", a_d_data, 32'hB5A4A5A5);
    chk("c_stall_c7", {31'h0, a_stall}, 32'h0);
    step();
    if_ce = 1'b0;
    step();

    // Test 5: partial store
    d_ce = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h10010004; d_wdata = 32'hDEADBEEF;
    step();
    chk("s_ce_we_c1", {30'h0, a_mem_ce, a_mem_we}, 32'h3);
    chk("s_sel_c1", {28'h0, a_mem_sel}, 32'h3);
    chk("s_wdata_c1", a_mem_wdata, 32'hDEADBEEF);
    chk("s_addr_c1", a_mem_addr, 32'h10010004);
    step();
    chk("s_ce_we_c2", {30'h0, a_mem_ce, a_mem_we}, 32'h0);
    step();
    chk("s_ready_c3", {31'h0, a_d_ready}, 32'h1);
    chk("s_ddata_keep", a_d_data, 32'hB5A4A5A5);
    step();
    d_ce = 1'b0; d_we = 1'b0;
    step();

    // Test 4: fetch starvation guard on instance b
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_ce = 1'b1; if_addr = 32'h00400040;
    d_ce = 1'b1; d_we = 1'b0; d_sel = 4'b0101; d_addr = 32'h10010020;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (!b_mem_ce && n < 20) begin
        step();
        n++;
      end
      chk("starve_grant_ce", {31'h0, b_mem_ce}, 32'h1);
      chk("starve_grant_sel", {28'h0, b_mem_sel}, {28'h0, exp_sel[g]});
      step();
    end
    if_ce = 1'b0; d_ce = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("starve_if_data", b_if_data, 32'hA5A5A5E5);
    chk("starve_d_data", b_d_data, 32'hB5A4A585);

    // Test 6: reset in WAIT with latency 3, then a clean restart
    d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h10010008;
    step();
    chk("ab_ce_c1", {31'h0, b_mem_ce}, 32'h1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; d_ce = 1'b0;
    chk("ab_ctl_after_rst", {24'h0, b_mem_ce, b_mem_we, b_mem_sel, b_if_ready, b_d_ready}, 32'h0);
    chk("ab_addr_after_rst", b_mem_addr, 32'h0);
    chk("ab_ddata_after_rst", b_d_data, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      seen = seen | b_d_ready | b_if_ready | b_mem_ce;
    end
    chk("ab_quiet", {31'h0, seen}, 32'h0);
    d_ce = 1'b1; d_addr = 32'h10010010;
    n = 0;
    while (!b_d_ready && n < 20) begin
      step();
      n++;
    end
    chk("ab_restart_latency", n, 32'd5);
    chk("ab_restart_data", b_d_data, 32'hB5A4A5B5);
    d_ce = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
